axis_channel_mux: RTL and testbench
===================================

AXIS_CHANNEL_MUX -- requirements
Module: axis_channel_mux

Interface
REQ-001 SHALL have parameter PARALLEL_SAMPLES, default 16, samples per beat per channel.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 16, bits per sample.
REQ-003 SHALL have parameter CHANNELS, default 8, number of output channels.
REQ-004 SHALL have parameter FUNCTIONS_PER_CHANNEL, default 1; input count N_IN = (1+FUNCTIONS_PER_CHANNEL)*CHANNELS.
REQ-005 SHALL define localparam SELECT_BITS = $clog2(N_IN) (4 at defaults) and DWIDTH = PARALLEL_SAMPLES*SAMPLE_WIDTH (256 at defaults).
REQ-006 SHALL have port clk, input, 1 bit, rising-edge clock for all logic.
REQ-007 SHALL have port reset, input, 1 bit, synchronous, active-high reset.
REQ-008 SHALL have port data_in, Axis_Parallel_If slave, N_IN channels x DWIDTH data, per-channel valid; the mux drives ready.
REQ-009 SHALL have port data_out, Axis_Parallel_If master, CHANNELS channels x DWIDTH data, per-channel valid; ready is ignored.
REQ-010 SHALL have port config_in, Axis_If slave, CHANNELS*SELECT_BITS data, valid; the mux drives ready; field [SELECT_BITS*k +: SELECT_BITS] is the source index for output k.
REQ-011 SHALL drive all other interface fields it owns (e.g. last) to 0.

Function
REQ-012 SHALL hold a select register sel[k], one per output channel k.
REQ-013 SHALL drive config_in.ready = 1 at all times.
REQ-014 SHALL load every sel[k] from config_in.data at each rising edge where config_in.valid=1; all fields update together.
REQ-015 SHALL drive data_in.ready = all ones; there is no backpressure.
REQ-016 SHALL register each output: at each edge, data_out.data[k] <= data_in.data[sel[k]] and data_out.valid[k] <= data_in.valid[sel[k]], using the pre-edge value of sel[k].
- Latency is 1 cycle.
- One output beat per accepted source beat; no drops, no duplicates, order preserved.
REQ-017 SHALL select with the old sel for a beat presented on the same edge as a config handshake; the new sel applies from the next edge.
REQ-018 SHALL allow several outputs to select the same input simultaneously (fan-out), each producing an identical stream.
REQ-019 SHALL drive valid[k]=0 and data[k]=0 on the next edge when sel[k] >= N_IN (out-of-range select; possible only when N_IN is not a power of two).
REQ-020 SHALL pass data bit-exactly with no per-sample arithmetic.

Reset
REQ-021 SHALL, while reset=1, set data_out.valid=0, data_out.data=0, and sel[k]=k (identity: output k sources input k).
REQ-022 SHALL ignore config_in and data_in during reset; a config handshake in the reset cycle is discarded.
REQ-023 SHALL discard the in-flight beat on reset asserted mid-stream; the first output beat after reset corresponds to the first input beat after reset.

Configuration
REQ-024 SHALL, when macro AXIS_CHANNEL_MUX_OUTPUT_REG_EN is defined, add a second register stage on data_out.data/valid (latency 2, reset to 0), with the select semantics of REQ-017 unchanged.
REQ-025 SHALL, without AXIS_CHANNEL_MUX_OUTPUT_REG_EN, have latency exactly 1 cycle.

Verification
REQ-026 SHALL cover identity mapping: after reset, drive all 16 input valids high with random data for 20 cycles -> output k carries input k beats 1 cycle later, 20 beats each.
REQ-027 SHALL cover reversed mapping: config sel[k]=15-k, random valid for 200 cycles -> per-channel output sequence equals input (15-k) valid-beat sequence, counts equal.
REQ-028 SHALL cover fan-out: config all sel=3, input 3 data 0x00..0F incrementing -> all 8 outputs emit identical 0x00..0F streams.
REQ-029 SHALL cover same-edge switch: config sel[0] from 0 to 9 while input 0 and 9 are valid every cycle -> the beat on the config edge comes from input 0, and subsequent beats come from input 9.
REQ-030 SHALL cover mid-stream reset: assert reset for 1 cycle during continuous valid -> outputs valid=0 and data=0 next cycle, and sel returns to identity.
REQ-031 SHALL cover 5 random reconfigurations, each followed by 200 random-valid cycles -> zero mismatches and equal counts per channel.

Source files
------------

// File: rtl/axis_channel_mux_if.sv
// AXI-stream style interfaces used by axis_channel_mux.
// Axis_Parallel_If: CHANNELS lanes of WIDTH-bit data, per-lane valid/ready/last.
// Axis_If: a single WIDTH-bit stream with valid/ready/last.

interface Axis_Parallel_If #(
    parameter int CHANNELS = 1,
    parameter int WIDTH    = 8
);
    logic [CHANNELS-1:0][WIDTH-1:0] data;
    logic [CHANNELS-1:0]            valid;
    logic [CHANNELS-1:0]            ready;
    logic [CHANNELS-1:0]            last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

interface Axis_If #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/axis_channel_mux.sv
// axis_channel_mux: routes any of N_IN parallel input streams to each of
// CHANNELS registered outputs, with a per-output select loaded from config_in.
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous, active-high; selects return to identity
//   data_in   - slave, N_IN lanes x DWIDTH, always ready
//   data_out  - master, CHANNELS lanes x DWIDTH, ready ignored, last = 0
//   config_in - slave, CHANNELS*SELECT_BITS select fields, always ready
// Build option: AXIS_CHANNEL_MUX_OUTPUT_REG_EN adds a second output
// register stage (latency 2 instead of 1).

module axis_channel_mux #(
    parameter int PARALLEL_SAMPLES      = 16,
    parameter int SAMPLE_WIDTH          = 16,
    parameter int CHANNELS              = 8,
    parameter int FUNCTIONS_PER_CHANNEL = 1
) (
    input  logic            clk,
    input  logic            reset,
    Axis_Parallel_If.slave  data_in,
    Axis_Parallel_If.master data_out,
    Axis_If.slave           config_in
);

    localparam int N_IN        = (1 + FUNCTIONS_PER_CHANNEL) * CHANNELS;
    localparam int SELECT_BITS = $clog2(N_IN);
    localparam int DWIDTH      = PARALLEL_SAMPLES * SAMPLE_WIDTH;

    logic [SELECT_BITS-1:0]         sel [CHANNELS];
    logic [CHANNELS-1:0][DWIDTH-1:0] stage_data;
    logic [CHANNELS-1:0]             stage_valid;

    assign config_in.ready = 1'b1;
    assign data_in.ready   = '1;
    assign data_out.last   = '0;

    // The output stage samples with the pre-edge select, so a config
    // handshake on the same edge only affects the following beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < CHANNELS; k++) begin
                sel[k] <= SELECT_BITS'(k);
            end
            stage_data  <= '0;
            stage_valid <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                // Out-of-range selects exist only when N_IN is not a
                // power of two; they produce an idle, zeroed lane.
                if (int'(sel[k]) < N_IN) begin
                    stage_data[k]  <= data_in.data[sel[k]];
                    stage_valid[k] <= data_in.valid[sel[k]];
                end else begin
                    stage_data[k]  <= '0;
                    stage_valid[k] <= 1'b0;
                end
                if (config_in.valid) begin
                    sel[k] <= config_in.data[SELECT_BITS*k +: SELECT_BITS];
                end
            end
        end
    end

`ifdef AXIS_CHANNEL_MUX_OUTPUT_REG_EN
    logic [CHANNELS-1:0][DWIDTH-1:0] out_data;
    logic [CHANNELS-1:0]             out_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= '0;
        end else begin
            out_data  <= stage_data;
            out_valid <= stage_valid;
        end
    end

    assign data_out.data  = out_data;
    assign data_out.valid = out_valid;
`else
    assign data_out.data  = stage_data;
    assign data_out.valid = stage_valid;
`endif

endmodule

// File: tb/tb_axis_channel_mux.sv
// Self-checking bench for axis_channel_mux at default parameters.
// Directed steps with a per-cycle expected-output pipeline.

module tb_axis_channel_mux;

    localparam int N_IN = 16;
    localparam int CH   = 8;
    localparam int SB   = 4;
    localparam int DW   = 256;
    localparam int DW1  = DW + 1;
`ifdef AXIS_CHANNEL_MUX_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset;

    Axis_Parallel_If #(.CHANNELS(N_IN), .WIDTH(DW)) din ();
    Axis_Parallel_If #(.CHANNELS(CH), .WIDTH(DW))   dout ();
    Axis_If #(.WIDTH(CH*SB))                        cfg ();

    axis_channel_mux dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (din),
        .data_out  (dout),
        .config_in (cfg)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [SB-1:0]  msel [CH];
    logic [DW1-1:0] pipe [2][CH];
    logic [DW-1:0]  a0;
    logic [DW-1:0]  b9;
    logic [CH*SB-1:0] rcfg;

    task automatic check(input string tag, input logic [DW1-1:0] obs,
                         input logic [DW1-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit all_valid);
        for (int i = 0; i < N_IN; i++) begin
            for (int w = 0; w < DW/32; w++) begin
                din.data[i][32*w +: 32] = $urandom();
            end
            din.valid[i] = all_valid ? 1'b1 : 1'($urandom_range(0, 1));
        end
    endtask

    // Expected output for this edge, then one clock, then compare.
    task automatic tick();
        logic [DW1-1:0] nxt [CH];
        for (int k = 0; k < CH; k++) begin
            nxt[k] = reset ? '0 : {din.valid[msel[k]], din.data[msel[k]]};
            pipe[1][k] = reset ? '0 : pipe[0][k];
            pipe[0][k] = nxt[k];
            if (reset) msel[k] = SB'(k);
            else if (cfg.valid) msel[k] = cfg.data[SB*k +: SB];
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < CH; k++) begin
            check($sformatf("out_ch%0d", k),
                  {dout.valid[k], dout.data[k]}, pipe[LAT-1][k]);
        end
    endtask

    initial begin
        for (int k = 0; k < CH; k++) begin
            msel[k] = SB'(k);
            pipe[0][k] = '0;
            pipe[1][k] = '0;
        end
        din.last   = '0;
        dout.ready = '0;
        cfg.last   = 1'b0;
        cfg.valid  = 1'b0;
        cfg.data   = '0;
        reset      = 1'b1;
        drive(1);

        // Reset state
        tick();
        tick();
        check("cfg_ready", DW1'(cfg.ready), DW1'(1));
        check("din_ready", DW1'(din.ready), DW1'(16'hFFFF));
        check("dout_last", DW1'(dout.last), DW1'(0));
        reset = 1'b0;

        // Identity mapping, all valid
        repeat (20) begin
            drive(1);
            tick();
        end

        // Reversed mapping: output k <- input 15-k
        for (int k = 0; k < CH; k++) rcfg[SB*k +: SB] = SB'(15 - k);
        cfg.data  = rcfg;
        cfg.valid = 1'b1;
        drive(0);
        tick();
        cfg.valid = 1'b0;
        repeat (200) begin
            drive(0);
            tick();
        end

        // Fan-out: all outputs from input 3, incrementing data
        cfg.data  = 32'h3333_3333;
        cfg.valid = 1'b1;
        drive(1);
        tick();
        cfg.valid = 1'b0;
        for (int j = 0; j < 16; j++) begin
            drive(0);
            din.valid[3] = 1'b1;
            din.data[3]  = DW'(j);
            tick();
        end
        drive(0);
        repeat (LAT) tick();

        // Same-edge switch of output 0 from input 0 to input 9
        cfg.data  = 32'h7654_3210;
        cfg.valid = 1'b1;
        drive(1);
        tick();
        drive(1);
        a0        = din.data[0];
        cfg.data  = 32'h7654_3219;
        tick();
        cfg.valid = 1'b0;
        drive(1);
        b9 = din.data[9];
        repeat (LAT - 1) tick();
        check("switch_old", {dout.valid[0], dout.data[0]}, {1'b1, a0});
        tick();
        check("switch_new", {dout.valid[0], dout.data[0]}, {1'b1, b9});

        // Mid-stream reset with a config handshake in the reset cycle
        cfg.data  = 32'h0123_4567;
        cfg.valid = 1'b1;
        drive(1);
        tick();
        cfg.valid = 1'b0;
        repeat (5) begin
            drive(1);
            tick();
        end
        drive(1);
        reset     = 1'b1;
        cfg.data  = 32'hFEDC_BA98;
        cfg.valid = 1'b1;
        tick();
        check("rst_valid", DW1'(dout.valid), '0);
        for (int k = 0; k < CH; k++) begin
            check($sformatf("rst_data%0d", k), DW1'(dout.data[k]), '0);
        end
        reset     = 1'b0;
        cfg.valid = 1'b0;
        repeat (20) begin
            drive(1);
            tick();
        end

        // Random reconfigurations
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < CH; k++) begin
                rcfg[SB*k +: SB] = SB'($urandom_range(0, 15));
            end
            cfg.data  = rcfg;
            cfg.valid = 1'b1;
            drive(0);
            tick();
            cfg.valid = 1'b0;
            repeat (200) begin
                drive(0);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
